// File: rtl/pcss_link_pkg.sv
// Shared constants and types for the PCSS inter-chip link (rx and tx sides).
package pcss_link_pkg;

  localparam int unsigned CHIPDATA_WIDTH = 16;
  localparam int unsigned FLITS          = 4;
  localparam int unsigned PKT_W          = CHIPDATA_WIDTH * FLITS;
  localparam int unsigned FLIT_IDX_W     = $clog2(FLITS);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } link_state_e;

endpackage : pcss_link_pkg

// File: rtl/link_sync.sv
// Multi-flop synchronizer for a single-bit level crossing into clk.
//   clk, rst_n : clock, async active-low reset (chain clears to 0)
//   d          : asynchronous input level
//   q          : synchronized level, STAGES edges after d
module link_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  // Shift chain; q is taken straight from the last flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= {chain_q[STAGES-2:0], d};
  end

  assign q = chain_q[STAGES-1];

endmodule : link_sync

// File: rtl/chip_link_rx.sv
// Inter-chip link receiver: 4-phase flit handshake with even parity in,
// reassembled 64-bit packet out to the router over valid/ready.
//   clk, rst_n        : clock, async active-low reset
//   recv_data_in/par  : flit data + even parity (bundled with valid)
//   recv_data_valid   : async flit request from the remote chip
//   recv_data_ready   : flit acknowledge
//   recv_data_err     : parity-fail flag, meaningful while ready=1
//   pkt_data/valid    : one-entry packet buffer toward the router
//   pkt_ready         : router accepts the buffered packet
//   par_err_cnt       : saturating parity-error count
module chip_link_rx
  import pcss_link_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] ERR_CNT_MAX = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHIPDATA_WIDTH-1:0] recv_data_in,
  input  logic                      recv_data_valid,
  input  logic                      recv_data_par,
  output logic                      recv_data_ready,
  output logic                      recv_data_err,
  output logic [PKT_W-1:0]          pkt_data,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic [15:0]               par_err_cnt
);

  localparam int unsigned STORE_W = PKT_W - CHIPDATA_WIDTH;

  link_state_e             state_q, state_d;
  logic                    vld_s;
  logic                    bad_c;
  logic                    drain_c;
  logic [FLIT_IDX_W-1:0]   flit_idx_q, flit_idx_d;
  logic [STORE_W-1:0]      stored_q, stored_d;
  logic                    ready_d, err_d, pkt_valid_d;
  logic [PKT_W-1:0]        pkt_data_d;
  logic [15:0]             cnt_d;

  link_sync #(.STAGES(SYNC_STAGES)) u_vld_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (recv_data_valid),
    .q     (vld_s)
  );

  assign bad_c   = ^{recv_data_in, recv_data_par};
  assign drain_c = pkt_valid & pkt_ready;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      flit_idx_q      <= '0;
      stored_q        <= '0;
      recv_data_ready <= 1'b0;
      recv_data_err   <= 1'b0;
      pkt_valid       <= 1'b0;
      pkt_data        <= '0;
      par_err_cnt     <= '0;
    end else begin
      state_q         <= state_d;
      flit_idx_q      <= flit_idx_d;
      stored_q        <= stored_d;
      recv_data_ready <= ready_d;
      recv_data_err   <= err_d;
      pkt_valid       <= pkt_valid_d;
      pkt_data        <= pkt_data_d;
      par_err_cnt     <= cnt_d;
    end
  end

  // Handshake FSM, flit assembly and packet buffer update.
  always_comb begin
    state_d     = state_q;
    flit_idx_d  = flit_idx_q;
    stored_d    = stored_q;
    ready_d     = recv_data_ready;
    err_d       = recv_data_err;
    pkt_valid_d = pkt_valid & ~pkt_ready;
    pkt_data_d  = pkt_data;
    cnt_d       = par_err_cnt;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        if (vld_s) begin
          if (bad_c) begin
            state_d = ACK;
            ready_d = 1'b1;
            err_d   = 1'b1;
            if (par_err_cnt != ERR_CNT_MAX) cnt_d = par_err_cnt + 16'd1;
          end else if (flit_idx_q != FLIT_IDX_W'(FLITS - 1)) begin
            // Flits arrive in order, so shifting fills slot flit_idx (slot 0 ends up MSB).
            stored_d   = {stored_q[STORE_W-CHIPDATA_WIDTH-1:0], recv_data_in};
            flit_idx_d = flit_idx_q + FLIT_IDX_W'(1);
            state_d    = ACK;
            ready_d    = 1'b1;
          end else if (!pkt_valid || drain_c) begin
            pkt_data_d  = {stored_q, recv_data_in};
            pkt_valid_d = 1'b1;
            flit_idx_d  = '0;
            state_d     = ACK;
            ready_d     = 1'b1;
          end
          // Last flit with a full, undrained buffer: hold ready low to stall the sender.
        end
      end
      ACK: begin
        if (!vld_s) begin
          state_d = IDLE;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule : chip_link_rx

// File: tb/tb_chip_link_rx.sv
// Directed bench for chip_link_rx: sender tasks drive 4-phase flits, a
// monitor checks packets leaving the router port against an expected queue.
module tb_chip_link_rx;

  localparam logic [15:0] ERR_MAX = 16'd24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] recv_data_in;
  logic        recv_data_valid;
  logic        recv_data_par;
  logic        recv_data_ready;
  logic        recv_data_err;
  logic [63:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [15:0] par_err_cnt;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  chip_link_rx #(.SYNC_STAGES(2), .ERR_CNT_MAX(ERR_MAX)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .recv_data_in    (recv_data_in),
    .recv_data_valid (recv_data_valid),
    .recv_data_par   (recv_data_par),
    .recv_data_ready (recv_data_ready),
    .recv_data_err   (recv_data_err),
    .pkt_data        (pkt_data),
    .pkt_valid       (pkt_valid),
    .pkt_ready       (pkt_ready),
    .par_err_cnt     (par_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet monitor: every accepted packet must match the next expected one.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          check("pkt_unexpected", pkt_data, 64'hx);
        end else begin
          e = exp_q.pop_front();
          check("pkt_data", pkt_data, e);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic flit_up(input logic [15:0] d, input logic flip);
    @(posedge clk); #1;
    recv_data_in    = d;
    recv_data_par   = (^d) ^ flip;
    recv_data_valid = 1'b1;
  endtask

  task automatic wait_ready(input logic lvl, input int bound, output int lat);
    lat = 0;
    while (recv_data_ready !== lvl && lat < bound) begin
      @(posedge clk); #1;
      lat++;
    end
    if (recv_data_ready !== lvl) lat = -1;
  endtask

  task automatic flit_down();
    int lat;
    recv_data_valid = 1'b0;
    wait_ready(1'b0, 10, lat);
    check("release_lat", 64'(lat), 64'd3);
  endtask

  task automatic send_flit(input logic [15:0] d, input logic flip, input logic exp_err);
    int lat;
    flit_up(d, flip);
    wait_ready(1'b1, 10, lat);
    check("ack_lat", 64'(lat), 64'd3);
    check("ack_err", 64'(recv_data_err), 64'(exp_err));
    flit_down();
  endtask

  task automatic send_pkt(input logic [63:0] p);
    for (int i = 0; i < 4; i++) send_flit(p[63 - 16*i -: 16], 1'b0, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int drops;
    rst_n = 1'b0; recv_data_in = '0; recv_data_valid = 1'b0;
    recv_data_par = 1'b0; pkt_ready = 1'b1;
    idle_cycles(3);
    check("rst_ready", 64'(recv_data_ready), 64'd0);
    check("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    check("rst_pkt_data", pkt_data, 64'd0);
    check("rst_cnt", 64'(par_err_cnt), 64'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Good packet straight through.
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    send_pkt(64'h0123_4567_89AB_CDEF);
    idle_cycles(4);

    // Flit 2 with bad parity, then resent.
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    send_flit(16'h0123, 1'b0, 1'b0);
    send_flit(16'h4567, 1'b0, 1'b0);
    send_flit(16'h89AB, 1'b1, 1'b1);
    check("err_cnt_1", 64'(par_err_cnt), 64'd1);
    send_flit(16'h89AB, 1'b0, 1'b0);
    send_flit(16'hCDEF, 1'b0, 1'b0);
    idle_cycles(4);

    // Backpressure: first packet held, last flit of second stalls.
    pkt_ready = 1'b0;
    exp_q.push_back(64'h1122_3344_5566_7788);
    exp_q.push_back(64'h99AA_BBCC_DDEE_FF00);
    send_pkt(64'h1122_3344_5566_7788);
    check("bp_valid", 64'(pkt_valid), 64'd1);
    check("bp_data_a", pkt_data, 64'h1122_3344_5566_7788);
    send_flit(16'h99AA, 1'b0, 1'b0);
    send_flit(16'hBBCC, 1'b0, 1'b0);
    send_flit(16'hDDEE, 1'b0, 1'b0);
    flit_up(16'hFF00, 1'b0);
    wait_ready(1'b1, 20, lat);
    check("bp_stall", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    check("bp_hold_a", pkt_data, 64'h1122_3344_5566_7788);
    @(posedge clk); #1; pkt_ready = 1'b1;
    @(posedge clk); #1; pkt_ready = 1'b0;
    wait_ready(1'b1, 4, lat);
    check("bp_ack_seen", 64'(lat >= 0), 64'd1);
    check("bp_valid_b", 64'(pkt_valid), 64'd1);
    check("bp_data_b", pkt_data, 64'h99AA_BBCC_DDEE_FF00);
    flit_down();
    pkt_ready = 1'b1;
    idle_cycles(4);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-packet.
    send_flit(16'h1234, 1'b0, 1'b0);
    send_flit(16'h5678, 1'b0, 1'b0);
    @(posedge clk); #1; rst_n = 1'b0; #1;
    check("mid_rst_ready", 64'(recv_data_ready), 64'd0);
    check("mid_rst_err", 64'(recv_data_err), 64'd0);
    check("mid_rst_valid", 64'(pkt_valid), 64'd0);
    check("mid_rst_data", pkt_data, 64'd0);
    check("mid_rst_cnt", 64'(par_err_cnt), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle_cycles(2);
    exp_q.push_back(64'hFFFF_0000_A5A5_5A5A);
    send_pkt(64'hFFFF_0000_A5A5_5A5A);
    idle_cycles(4);

    // Valid held high for 20 cycles on flit 0.
    flit_up(16'h1111, 1'b0);
    wait_ready(1'b1, 10, lat);
    check("hold_ack_lat", 64'(lat), 64'd3);
    drops = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (recv_data_ready !== 1'b1) drops++;
    end
    check("hold_ready_stays", 64'(drops), 64'd0);
    flit_down();
    check("hold_flit_idx", 64'(dut.flit_idx_q), 64'd1);
    exp_q.push_back(64'h1111_2222_3333_4444);
    send_flit(16'h2222, 1'b0, 1'b0);
    send_flit(16'h3333, 1'b0, 1'b0);
    send_flit(16'h4444, 1'b0, 1'b0);
    idle_cycles(4);

    // Error counter saturation, then a good packet still assembles.
    for (int i = 0; i < int'(ERR_MAX) + 6; i++) begin
      send_flit(16'h00F0 + 16'(i), 1'b1, 1'b1);
      if (i == 0) check("sat_first", 64'(par_err_cnt), 64'd1);
    end
    check("sat_cnt", 64'(par_err_cnt), 64'(ERR_MAX));
    check("sat_flit_idx", 64'(dut.flit_idx_q), 64'd0);
    exp_q.push_back(64'hDEAD_BEEF_0F0F_7E57);
    send_pkt(64'hDEAD_BEEF_0F0F_7E57);
    idle_cycles(6);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_chip_link_rx
